// File: rtl/vga_pkg.sv
// Shared 800x600@60 (40 MHz pixel clock) timing constants and helpers for
// the VGA timing generator.
package vga_pkg;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int VGA_H_ACTIVE     = 800;
  localparam int VGA_H_TOTAL      = 1056;
  localparam int VGA_H_SYNC_START = 840;
  localparam int VGA_H_SYNC_END   = 968;

  localparam int VGA_V_ACTIVE     = 600;
  localparam int VGA_V_TOTAL      = 628;
  localparam int VGA_V_SYNC_START = 601;
  localparam int VGA_V_SYNC_END   = 605;

  localparam int FRAME_CNT_W = 16;

  // True when lo <= v < hi (half-open window used for sync pulses).
  function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus registered sync and
// blank flags. The flags are decoded from the next count value so they
// line up with count_out on the same cycle.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE     = VGA_H_ACTIVE,
  parameter int TOTAL      = VGA_H_TOTAL,
  parameter int SYNC_START = VGA_H_SYNC_START,
  parameter int SYNC_END   = VGA_H_SYNC_END
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en_in,
  output logic [10:0] count_out,
  output logic        wrap_out,
  output logic        sync_out,
  output logic        blnk_out
);

  localparam cnt_t LAST   = cnt_t'(TOTAL - 1);
  localparam cnt_t ACT    = cnt_t'(ACTIVE);
  localparam cnt_t SYNC_S = cnt_t'(SYNC_START);
  localparam cnt_t SYNC_E = cnt_t'(SYNC_END);

  cnt_t r_count;
  logic r_sync;
  logic r_blnk;
  cnt_t w_next;
  logic w_at_end;
  logic w_wrap;

  // Next count: advance when enabled, wrap from TOTAL-1 back to 0.
  always_comb begin
    w_at_end = (r_count == LAST);
    w_wrap   = en_in && w_at_end;
    w_next   = r_count;
    if (en_in) begin
      w_next = w_at_end ? '0 : r_count + cnt_t'(1);
    end
  end

  // Count and flags registered together so they never skew.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_count <= '0;
      r_sync  <= 1'b0;
      r_blnk  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_sync  <= in_window(w_next, SYNC_S, SYNC_E);
      r_blnk  <= (w_next >= ACT);
    end
  end

  assign count_out = r_count;
  assign wrap_out  = w_wrap;
  assign sync_out  = r_sync;
  assign blnk_out  = r_blnk;

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: horizontal and vertical axis counters chained by the
// horizontal wrap, plus a frame-start pulse at pixel (0,0).
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit completed-frame
// counter on port frame_cnt_out.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_TOTAL      = VGA_H_TOTAL,
  parameter int H_SYNC_START = VGA_H_SYNC_START,
  parameter int H_SYNC_END   = VGA_H_SYNC_END,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_TOTAL      = VGA_V_TOTAL,
  parameter int V_SYNC_START = VGA_V_SYNC_START,
  parameter int V_SYNC_END   = VGA_V_SYNC_END
) (
  input  logic        pclk_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        frame_start_out
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt_out
`endif
);

  logic r_started;
  logic r_frame_start;
  logic w_h_wrap;
  logic w_v_wrap;

  // Reset loads pixel (0,0) with the pulse cleared; the first edge after
  // release holds (0,0) and raises frame_start, then counting begins.
  always_ff @(posedge pclk_in) begin
    if (rst_in) begin
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
    end
  end

  vga_axis_counter #(
    .ACTIVE     (H_ACTIVE),
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END)
  ) u_h_axis (
    .clk_in    (pclk_in),
    .rst_in    (rst_in),
    .en_in     (r_started),
    .count_out (hcount_out),
    .wrap_out  (w_h_wrap),
    .sync_out  (hsync_out),
    .blnk_out  (hblnk_out)
  );

  vga_axis_counter #(
    .ACTIVE     (V_ACTIVE),
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END)
  ) u_v_axis (
    .clk_in    (pclk_in),
    .rst_in    (rst_in),
    .en_in     (w_h_wrap),
    .count_out (vcount_out),
    .wrap_out  (w_v_wrap),
    .sync_out  (vsync_out),
    .blnk_out  (vblnk_out)
  );

  // Frame-start pulse: either the post-reset (0,0) or a full-frame wrap.
  always_ff @(posedge pclk_in) begin
    if (rst_in) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= !r_started || w_v_wrap;
    end
  end

  assign frame_start_out = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  // Counts wrap-driven frame starts only; the post-reset pulse is not counted.
  always_ff @(posedge pclk_in) begin
    if (rst_in) begin
      r_frame_cnt <= '0;
    end else if (w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt_out = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing using a reduced timing set so several frames fit
// in a short run. Expected values come from hand-written boundary vectors
// and from a pixel-index model: output k after reset release is pixel
// k mod (H_TOTAL*V_TOTAL).
module tb_vga_timing;

  localparam int HA  = 16;
  localparam int HT  = 24;
  localparam int HSS = 18;
  localparam int HSE = 21;
  localparam int VA  = 6;
  localparam int VT  = 10;
  localparam int VSS = 7;
  localparam int VSE = 9;
  localparam int FT  = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic        fstart;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fcnt;
`endif

  always #5 clk = ~clk;

  vga_timing #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE)
  ) dut (
    .pclk_in         (clk),
    .rst_in          (rst),
    .hcount_out      (hcount),
    .hsync_out       (hsync),
    .hblnk_out       (hblnk),
    .vcount_out      (vcount),
    .vsync_out       (vsync),
    .vblnk_out       (vblnk),
    .frame_start_out (fstart)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt_out   (fcnt)
`endif
  );

  typedef struct {
    int   k;
    int   h;
    int   v;
    logic hs;
    logic hb;
    logic vs;
    logic vb;
    logic fs;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   k        = 0;  // index of the next output after release
  int   fc_base  = 0;
  logic in_rst   = 1'b1;

  function automatic int pack(int h, int v, logic hs, logic hb, logic vs, logic vb, logic fs);
    return (h << 16) | (v << 5) | (int'(hs) << 4) | (int'(hb) << 3) |
           (int'(vs) << 2) | (int'(vb) << 1) | int'(fs);
  endfunction

  function automatic int dut_packed();
    return pack(int'(hcount), int'(vcount), hsync, hblnk, vsync, vblnk, fstart);
  endfunction

  function automatic int model_packed(int kk);
    int p;
    int h;
    int v;
    p = kk % FT;
    h = p % HT;
    v = p / HT;
    return pack(h, v, (h >= HSS) && (h < HSE), h >= HA, (v >= VSS) && (v < VSE), v >= VA, p == 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r);
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      in_rst  = 1'b1;
      k       = 0;
      fc_base = 0;
    end else begin
      in_rst = 1'b0;
      k++;
    end
  endtask

  task automatic check_model(input string tag);
    if (in_rst) begin
      chk({tag, "_rst"}, dut_packed(), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk({tag, "_rst_fcnt"}, int'(fcnt), 0);
`endif
    end else begin
      chk(tag, dut_packed(), model_packed(k - 1));
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk({tag, "_fcnt"}, int'(fcnt), (fc_base + (k - 1) / FT) % 65536);
`endif
    end
  endtask

  vec_t vecs[$];
  int   last_fs;

  initial begin
    vecs.push_back('{0,   0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1,   1,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{15,  15, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16,  16, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{17,  17, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{18,  18, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{20,  20, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{21,  21, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{23,  23, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{24,  0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{143, 23, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{144, 0,  6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{168, 0,  7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{197, 5,  8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{216, 0,  9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{239, 23, 9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{240, 0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

    // Reset held for 5 cycles: everything reads zero.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1);
      check_model("reset_hold");
    end

    // Boundary vectors from hand-derived timing.
    foreach (vecs[i]) begin
      for (int g = 0; g < 2 * FT && (k == 0 || k - 1 < vecs[i].k); g++) begin
        cycle(1'b0);
      end
      chk($sformatf("vec_k%0d", vecs[i].k), dut_packed(),
          pack(vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].hb, vecs[i].vs, vecs[i].vb, vecs[i].fs));
    end

    // Full frames against the model, with frame-start spacing measured.
    last_fs = FT;
    for (int g = 0; g < 3 * FT && k - 1 < 3 * FT + 1; g++) begin
      cycle(1'b0);
      check_model("frames");
      if (fstart) begin
        chk("frame_period", (k - 1) - last_fs, FT);
        last_fs = k - 1;
      end
    end

    // Mid-frame reset at h=10, v=5 for one cycle.
    for (int g = 0; g < 2 * FT && ((k - 1) % FT) != 5 * HT + 10; g++) begin
      cycle(1'b0);
    end
    chk("midreset_pos", dut_packed() >> 5, pack(10, 5, 0, 0, 0, 0, 0) >> 5);
    cycle(1'b1);
    check_model("midreset_during");
    cycle(1'b0);
    chk("midreset_first", dut_packed(), pack(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int g = 0; g < 30; g++) begin
      cycle(1'b0);
      check_model("after_midreset");
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Preload the frame counter to 65535 and run into the next frame.
    force dut.r_frame_cnt = 16'hFFFF;
    #2;
    release dut.r_frame_cnt;
    fc_base = 65535 - (k - 1) / FT;
    for (int g = 0; g < 2 * FT && ((k - 1) % FT) != 0; g++) begin
      cycle(1'b0);
      check_model("preload");
    end
    chk("fcnt_wrap", int'(fcnt), 0);
`endif

    // Random reset pulses against the model.
    for (int g = 0; g < 1500; g++) begin
      if ($urandom_range(0, 199) == 0) begin
        int len;
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          cycle(1'b1);
          check_model("rand_rst");
        end
      end
      cycle(1'b0);
      check_model("rand_run");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter H_ACTIVE SHALL default to 800: visible pixels per line.
REQ-003 Parameter H_TOTAL SHALL default to 1056: pixel clocks per line.
REQ-004 Parameter H_SYNC_START SHALL default to 840 and H_SYNC_END to 968: first cycle of hsync, and first cycle after hsync.
REQ-005 Parameter V_ACTIVE SHALL default to 600: visible lines per frame.
REQ-006 Parameter V_TOTAL SHALL default to 628: lines per frame.
REQ-007 Parameter V_SYNC_START SHALL default to 601 and V_SYNC_END to 605: first line of vsync, and first line after vsync.
REQ-008 Port pclk_in SHALL be an input, 1 bit: pixel clock, 40 MHz.
REQ-009 Port rst_in SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-010 Port hcount_out SHALL be an output, 11 bits: pixel position within the line.
REQ-011 Port hsync_out SHALL be an output, 1 bit: horizontal sync, active-high.
REQ-012 Port hblnk_out SHALL be an output, 1 bit: horizontal blanking.
REQ-013 Port vcount_out SHALL be an output, 11 bits: line position within the frame.
REQ-014 Port vsync_out SHALL be an output, 1 bit: vertical sync, active-high.
REQ-015 Port vblnk_out SHALL be an output, 1 bit: vertical blanking.
REQ-016 Port frame_start_out SHALL be an output, 1 bit: one-cycle pulse at pixel (0,0).
REQ-017 Port frame_cnt_out SHALL be an output, 16 bits: completed-frame count (present only with the macro; see Configuration).

Function
REQ-018 hcount SHALL increment by 1 every pclk_in cycle and SHALL wrap from H_TOTAL-1 to 0.
REQ-019 vcount SHALL increment by 1 only in the cycle where hcount wraps, and SHALL wrap from V_TOTAL-1 to 0 when hcount and vcount wrap in the same cycle.
REQ-020 All outputs SHALL be registered; each flag SHALL be decoded from the next-state counter values, so the flags and counts on the outputs always describe the same pixel with zero skew.
REQ-021 hblnk_out SHALL be 1 if and only if hcount_out >= H_ACTIVE.
REQ-022 hsync_out SHALL be 1 if and only if H_SYNC_START <= hcount_out < H_SYNC_END.
REQ-023 vblnk_out SHALL be 1 if and only if vcount_out >= V_ACTIVE.
REQ-024 vsync_out SHALL be 1 if and only if V_SYNC_START <= vcount_out < V_SYNC_END.
REQ-025 frame_start_out SHALL be 1 for exactly the one cycle in which hcount_out = 0 and vcount_out = 0, including the first cycle after reset is released.
REQ-026 Counter arithmetic SHALL be 11-bit unsigned, and no count SHALL ever exceed its TOTAL-1.
REQ-027 Downstream drawing stages SHALL see a period of exactly H_TOTAL*V_TOTAL = 663168 cycles per frame.

Reset
REQ-028 While rst_in = 1 on a pclk_in edge, all counts SHALL be forced to 0, all sync and blank outputs to 0, frame_start_out to 0, and frame_cnt_out to 0.
REQ-029 Reset asserted mid-line or mid-frame SHALL abort the frame, and the first cycle after release SHALL output pixel (0,0) with frame_start_out = 1.

Configuration
REQ-030 With macro VGA_TIMING_FRAME_CNT_EN defined, frame_cnt_out SHALL increment by 1 (modulo 2^16, wrapping 65535 to 0) in the same cycle frame_start_out rises, except the first pulse after reset.
REQ-031 Without VGA_TIMING_FRAME_CNT_EN, the port frame_cnt_out and its register SHALL be absent.

Structure
REQ-032 The 800x600@60 timing constants SHALL live in shared package vga_pkg, and the parameter defaults SHALL reference it.
REQ-033 One sub-module, vga_axis_counter (count, wrap, sync/blank decode for one axis), SHALL be instantiated twice, once for horizontal and once for vertical, with the horizontal wrap driving the vertical enable.

Verification
REQ-034 Reset: hold rst_in for 5 cycles, then release -> first output is hcount 0, vcount 0, frame_start_out 1, all syncs and blanks 0.
REQ-035 Horizontal: run one line -> hblnk rises at hcount 800; hsync is high for hcount 840..967 (128 cycles); hcount wraps 1055 -> 0 while vcount goes 0 -> 1.
REQ-036 Vertical: run one frame -> vblnk is high for lines 600..627; vsync is high for lines 601..604; frame_start_out pulses are exactly 663168 cycles apart.
REQ-037 Mid-frame reset: assert rst_in at hcount 500, vcount 300 for 1 cycle -> next cycle outputs pixel (0,0) with frame_start_out 1.
REQ-038 With VGA_TIMING_FRAME_CNT_EN: run 3 frames -> frame_cnt_out reads 0, 1, 2; preloading the counter to 65535 and running one more frame -> it wraps to 0.
